// File: rtl/pll_reset_sequencer.sv
// Power-up and recovery sequencer for the system and audio PLLs, the AES50 DDR
// clock-forwarding output and the downstream system reset.
module pll_reset_sequencer #(
  parameter int RST_CYCLES         = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int DDR_SETTLE         = 8,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       pll_audio_lock,
  input  logic       restart,
  input  logic       aes50_clk_en,
  output logic       pll_rst,
  output logic       pll_audio_rst,
  output logic       ddr_reset,
  output logic [1:0] ddr_data,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_RESET_PLL   = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_RELEASE_DDR = 3'd2,
    ST_RUN         = 3'd3,
    ST_FAULT       = 3'd4
  } state_t;

  localparam int MAX_A   = (RST_CYCLES > DDR_SETTLE) ? RST_CYCLES : DDR_SETTLE;
  localparam int MAX_CNT = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int SW      = $clog2(LOCK_STABLE_CYCLES + 1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [SW-1:0] stable_r, stable_s;
  logic [1:0]    retry_r, retry_s, retry_inc_s;
  logic [7:0]    loss_r, loss_s;
  logic [1:0]    sync1_r, sync2_r;
  logic          locks_ok_s;
  logic          enter_s;
  logic [7:0]    dec_s;

  // {pll_rst, pll_audio_rst, ddr_reset, ddr_data[1:0], sys_rst, ready, fault}
  function automatic logic [7:0] decode_outputs(input state_t s, input logic clk_en);
    case (s)
      ST_RESET_PLL:   decode_outputs = 8'b1110_0100;
      ST_WAIT_LOCK:   decode_outputs = 8'b0010_0100;
      ST_RELEASE_DDR: decode_outputs = 8'b0000_0100;
      ST_RUN:         decode_outputs = {3'b000, (clk_en ? 2'b10 : 2'b00), 3'b010};
      ST_FAULT:       decode_outputs = 8'b1110_0101;
      default:        decode_outputs = 8'b1110_0100;
    endcase
  endfunction

  assign locks_ok_s  = &sync2_r;
  assign retry_inc_s = retry_r + 2'd1;
  assign dec_s       = decode_outputs(state_s, aes50_clk_en);

  // Two-flop synchronizers for both asynchronous lock inputs
  always_ff @(posedge refclk) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {pll_audio_lock, pll_lock};
      sync2_r <= sync1_r;
    end
  end

  // Next-state, counter and retry/loss bookkeeping; restart overrides everything
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    stable_s = stable_r;
    retry_s  = retry_r;
    loss_s   = loss_r;
    if (restart) begin
      state_s = ST_RESET_PLL;
      retry_s = 2'd0;
    end else begin
      case (state_r)
        ST_RESET_PLL: begin
          if (cnt_r == CW'(RST_CYCLES - 1)) state_s = ST_WAIT_LOCK;
          else                              state_s = ST_RESET_PLL;
        end
        ST_WAIT_LOCK: begin
          stable_s = locks_ok_s ? stable_r + {{(SW-1){1'b0}}, 1'b1} : {SW{1'b0}};
          if (locks_ok_s && (stable_r == SW'(LOCK_STABLE_CYCLES - 1))) begin
            state_s = ST_RELEASE_DDR;
          end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
            retry_s = retry_inc_s;
            state_s = (retry_inc_s == 2'(MAX_RETRIES)) ? ST_FAULT : ST_RESET_PLL;
          end else begin
            state_s = ST_WAIT_LOCK;
          end
        end
        ST_RELEASE_DDR: begin
          if (!locks_ok_s) begin
            state_s = ST_RESET_PLL;
            loss_s  = (loss_r == 8'hFF) ? loss_r : loss_r + 8'd1;
          end else if (cnt_r == CW'(DDR_SETTLE - 1)) begin
            state_s = ST_RUN;
            retry_s = 2'd0;
          end else begin
            state_s = ST_RELEASE_DDR;
          end
        end
        ST_RUN: begin
          if (!locks_ok_s) begin
            state_s = ST_RESET_PLL;
            loss_s  = (loss_r == 8'hFF) ? loss_r : loss_r + 8'd1;
          end else begin
            state_s = ST_RUN;
          end
        end
        ST_FAULT: state_s = ST_FAULT;
        default:  state_s = ST_RESET_PLL;
      endcase
    end
    // A restart re-enters RESET_PLL even from RESET_PLL, so it also clears counters
    enter_s = restart || (state_s != state_r);
    if (enter_s) begin
      cnt_s    = {CW{1'b0}};
      stable_s = {SW{1'b0}};
    end else begin
      cnt_s    = cnt_s;
      stable_s = stable_s;
    end
  end

  // State, counters and outputs registered together so outputs track the state edge
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_r       <= ST_RESET_PLL;
      cnt_r         <= {CW{1'b0}};
      stable_r      <= {SW{1'b0}};
      retry_r       <= 2'd0;
      loss_r        <= 8'd0;
      pll_rst       <= 1'b1;
      pll_audio_rst <= 1'b1;
      ddr_reset     <= 1'b1;
      ddr_data      <= 2'b00;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      stable_r      <= stable_s;
      retry_r       <= retry_s;
      loss_r        <= loss_s;
      {pll_rst, pll_audio_rst, ddr_reset, ddr_data, sys_rst, ready, fault} <= dec_s;
    end
  end

  assign state         = state_r;
  assign retry_cnt     = retry_r;
  assign lock_loss_cnt = loss_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expectations are queued when stimulus
// is applied and compared when the DUT reaches the corresponding point.
module tb_pll_reset_sequencer;

  logic       refclk = 1'b0;
  logic       reset, pll_lock, pll_audio_lock, restart, aes50_clk_en;
  logic       pll_rst, pll_audio_rst, ddr_reset, sys_rst, ready, fault;
  logic [1:0] ddr_data, retry_cnt;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   n;

  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT(32),
    .DDR_SETTLE(2), .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk), .reset(reset), .pll_lock(pll_lock),
    .pll_audio_lock(pll_audio_lock), .restart(restart),
    .aes50_clk_en(aes50_clk_en), .pll_rst(pll_rst),
    .pll_audio_rst(pll_audio_rst), .ddr_reset(ddr_reset),
    .ddr_data(ddr_data), .sys_rst(sys_rst), .ready(ready), .fault(fault),
    .state(state), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check_val(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic expect_val(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic score(input int got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge refclk);
  endtask

  // mode 0 waits on ready, mode 1 waits on state; n = edges waited
  task automatic wait_for(input string tag, input int mode, input int target,
                          input int max, output int cnt);
    cnt = 0;
    while (cnt < max && ((mode == 0) ? (int'(ready) != target) : (int'(state) != target))) begin
      step(1);
      cnt++;
    end
    if ((mode == 0) ? (int'(ready) != target) : (int'(state) != target)) begin
      chk_cnt++;
      $display("FAIL %s: condition not reached within %0d edges", tag, max);
    end
  endtask

  initial begin
    reset = 1'b1; pll_lock = 1'b1; pll_audio_lock = 1'b1;
    restart = 1'b0; aes50_clk_en = 1'b1;
    step(3);

    expect_val("rst_state", 0);     score(state);
    expect_val("rst_pll_rst", 1);   score(pll_rst);
    expect_val("rst_audio_rst", 1); score(pll_audio_rst);
    expect_val("rst_ddr_reset", 1); score(ddr_reset);
    expect_val("rst_ddr_data", 0);  score(ddr_data);
    expect_val("rst_sys_rst", 1);   score(sys_rst);
    expect_val("rst_ready", 0);     score(ready);
    expect_val("rst_fault", 0);     score(fault);
    expect_val("rst_retry", 0);     score(retry_cnt);
    expect_val("rst_loss", 0);      score(lock_loss_cnt);

    // Clean start with locks tied high
    reset = 1'b0;
    step(4);
    expect_val("wait_entry_state", 1); score(state);
    expect_val("wait_pll_rst", 0);     score(pll_rst);
    wait_for("clean_ready", 0, 1, 40, n);
    expect_val("clean_ready_edge", 14); score(4 + n);
    expect_val("run_sys_rst", 0);   score(sys_rst);
    expect_val("run_ddr_reset", 0); score(ddr_reset);
    expect_val("run_ddr_data", 2);  score(ddr_data);
    expect_val("run_state", 3);     score(state);

    aes50_clk_en = 1'b0; step(1);
    expect_val("clk_en_off_data", 0); score(ddr_data);
    aes50_clk_en = 1'b1; step(1);
    expect_val("clk_en_on_data", 2);  score(ddr_data);

    // One-cycle audio lock drop in RUN
    pll_audio_lock = 1'b0; step(1);
    pll_audio_lock = 1'b1; step(1);
    expect_val("loss_e2_sys_rst", 0); score(sys_rst);
    step(1);
    expect_val("loss_sys_rst", 1); score(sys_rst);
    expect_val("loss_ready", 0);   score(ready);
    expect_val("loss_state", 0);   score(state);
    expect_val("loss_cnt", 1);     score(lock_loss_cnt);
    wait_for("rerun_ready", 0, 1, 40, n);
    expect_val("rerun_edges", 14); score(n);

    // Restart coinciding with a lock loss in RUN
    pll_lock = 1'b0; step(1);
    pll_lock = 1'b1; step(1);
    restart = 1'b1;  step(1);
    restart = 1'b0;
    expect_val("restart_loss_state", 0); score(state);
    expect_val("restart_loss_cnt", 1);   score(lock_loss_cnt);
    expect_val("restart_retry", 0);      score(retry_cnt);

    // Drive enough lock losses to saturate the counter
    for (int i = 0; i < 300; i++) begin
      wait_for("sat_run", 1, 3, 40, n);
      pll_lock = 1'b0; step(1);
      pll_lock = 1'b1; step(3);
      if (i == 252) begin
        expect_val("loss_cnt_254", 254); score(lock_loss_cnt);
      end
    end
    expect_val("loss_cnt_sat", 255); score(lock_loss_cnt);

    // Reset asserted from RUN
    wait_for("pre_reset_run", 1, 3, 40, n);
    reset = 1'b1; step(1);
    expect_val("midrst_state", 0);     score(state);
    expect_val("midrst_ready", 0);     score(ready);
    expect_val("midrst_sys_rst", 1);   score(sys_rst);
    expect_val("midrst_ddr_reset", 1); score(ddr_reset);
    expect_val("midrst_ddr_data", 0);  score(ddr_data);
    expect_val("midrst_pll_rst", 1);   score(pll_rst);
    expect_val("midrst_loss", 0);      score(lock_loss_cnt);

    // Lock glitch in WAIT_LOCK cycle 5 delays RELEASE_DDR by 6 cycles
    step(1);
    reset = 1'b0;
    step(7);
    pll_lock = 1'b0; step(1);
    pll_lock = 1'b1;
    wait_for("glitch_ready", 0, 1, 60, n);
    expect_val("glitch_ready_edge", 20); score(8 + n);
    expect_val("glitch_retry", 0);       score(retry_cnt);

    // Locks never assert: two timeouts then FAULT
    reset = 1'b1; pll_lock = 1'b0; pll_audio_lock = 1'b0;
    step(2);
    reset = 1'b0;
    step(38);
    expect_val("retry1_state", 0); score(state);
    expect_val("retry1_cnt", 1);   score(retry_cnt);
    wait_for("fault_wait", 1, 4, 100, n);
    expect_val("fault_edge", 72);      score(38 + n);
    expect_val("fault_flag", 1);       score(fault);
    expect_val("fault_pll_rst", 1);    score(pll_rst);
    expect_val("fault_audio_rst", 1);  score(pll_audio_rst);
    expect_val("fault_ddr_reset", 1);  score(ddr_reset);
    expect_val("fault_sys_rst", 1);    score(sys_rst);
    expect_val("fault_retry", 2);      score(retry_cnt);
    step(20);
    expect_val("fault_hold_state", 4); score(state);
    restart = 1'b1; step(1);
    restart = 1'b0;
    expect_val("fault_restart_state", 0); score(state);
    expect_val("fault_restart_retry", 0); score(retry_cnt);
    expect_val("fault_restart_fault", 0); score(fault);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
